game_layer_mixer: RTL and testbench
===================================

# game_layer_mixer

Parametrised VGA pixel compositor that replaces fixed per-screen picture overlays with NUM_LAYERS runtime-configurable sprite/picture windows over a 2x-upscaled 8-bit background. It generates the ROM addresses for the background and every layer from the scan position and drives one 12-bit RGB pixel per clock to the VGA output stage. Layers are merged by priority with a transparency key and optional per-layer blink. Window configuration is double-buffered so changes never tear mid-frame.

## Interface

Parameters:
- NUM_LAYERS, 4, number of overlay layers; 1..8.
- ADDR_W, 17, ROM address width for background and every layer.
- KEY_COLOR, 12'h000, layer pixel value treated as transparent.
- BG_W, 320, background ROM row pitch in source pixels.

Ports (clock and reset first):
- clk  in  1  pixel clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- VGA_xpos  in  11  current scan x; active area 1..640.
- VGA_ypos  in  11  current scan y; active area 1..480.
- frame_start  in  1  one-cycle pulse at frame boundary; commits pending config.
- blink_tick  in  1  one-cycle pulse; toggles blink phase.
- cfg_we  in  1  config write strobe, one cycle per write.
- cfg_sel  in  3  target layer index.
- cfg_x0, cfg_y0  in  11 each  window origin; window is x0 < x <= x0+w, y0 < y <= y0+h.
- cfg_w, cfg_h  in  11 each  window size in pixels; w = 0 or h = 0 means an empty window.
- cfg_en  in  1  layer enable.
- cfg_blink  in  1  layer blinks with the blink phase.
- cfg_pending  out  1  a shadow write has not yet been committed.
- bg_addr  out  ADDR_W  background ROM address.
- bg_pix  in  8  background ROM data, valid 1 clk after bg_addr; format R[7:5] G[4:2] B[1:0].
- layer_addr  out  NUM_LAYERS*ADDR_W  per-layer ROM address; layer i occupies slice [i*ADDR_W +: ADDR_W].
- layer_pix  in  NUM_LAYERS*12  per-layer ROM data, valid 1 clk after layer_addr.
- VGA_data  out  12  composed pixel {R4,G4,B4}.

## Operation

- Config: each layer has a shadow set and an active set {x0, y0, w, h, en, blink}.
  - cfg_we writes the shadow set of layer cfg_sel and sets cfg_pending.
  - cfg_sel >= NUM_LAYERS: write ignored; cfg_pending unchanged.
  - On frame_start, all shadow sets are copied to the active sets and cfg_pending clears.
  - cfg_we together with frame_start: the same-cycle write is included in the commit, and cfg_pending ends at 0.
- Blink: blink_phase toggles on each blink_tick. A layer with blink=1 is treated as not hit while blink_phase=1.
- Stage A (registered):
  - hit_i = en_i & inside window_i.
  - layer_addr_i = (x - x0_i - 1) + w_i*(y - y0_i - 1), truncated to ADDR_W. It holds its previous value when hit_i=0.
  - bg_addr = x[10:1] + BG_W*y[10:1], truncated to ADDR_W, inside 1..640 x 1..480. It holds its previous value outside that area.
  - Hit flags and blink gating are delayed to align with ROM data.
- Stage B (ROM latency, 1 clk): the ROM returns layer_pix and bg_pix.
- Stage C (registered output):
  - The winner is the highest-index layer with a delayed hit and layer_pix_i != KEY_COLOR.
  - VGA_data = the winner's pixel. If no layer wins, VGA_data = background expanded as R4={r,r[2]}, G4={g,g[2]}, B4={b,b}.
- Reset: active and shadow sets all zero (every layer disabled); cfg_pending=0; blink_phase=0; bg_addr=0; all layer_addr=0; delayed hit flags=0; VGA_data=0.
- Reset mid-frame: the pipeline flushes. VGA_data is 0 for the reset cycle and stays 0 until valid data reaches stage C.

## Timing

- Latency is 3 clks from VGA_xpos/VGA_ypos to VGA_data:
  - addresses registered at n+1;
  - ROM data at n+2;
  - VGA_data at n+3.
- Throughput is one pixel per clock with no stalls.
- Config commit takes effect for scan positions presented from the cycle after frame_start.
- blink_phase change takes effect for scan positions presented from the cycle after blink_tick.
- Window arithmetic is done at 22 bits before truncation. x0+w and y0+h are computed at 12 bits, so a window extending past 2047 does not wrap.

## Test plan

- Reset, then sweep a full 640x480 frame with no layers enabled and bg_pix = bg_addr[7:0] -> bg_addr at (x=3,y=5) is 1+320*2=641. VGA_data at n+3 equals the expansion of 641[7:0]=8'h81: R4=4'h9, G4=4'h0, B4=4'h5, so VGA_data = 12'h905.
- Write layer0 {x0=130, y0=120, w=380, h=180, en=1}, then frame_start -> cfg_pending goes 1 then 0. At (131,121) layer_addr0=0; at (510,300) it is 379+380*179=68399. Outside the window, VGA_data is background.
- Layer1 overlapping layer0, with layer1 pixels 12'hFF0 except KEY pixels of 12'h000 -> where layer1 is opaque, VGA_data=12'hFF0. Where layer1 is KEY, the output shows layer0's pixel, or background if layer0 is also KEY.
- Write a new config mid-frame without frame_start -> output unchanged for the rest of the frame and cfg_pending=1. The next frame_start applies it. cfg_we with cfg_sel=5 (NUM_LAYERS=4) -> ignored.
- Layer2 with blink=1, then toggle blink_tick -> layer2 is hidden on alternate phases, with the switch visible 3 clks after the tick. Assert rst mid-frame -> next-cycle VGA_data=0, all layers disabled, blink_phase=0.

Source files
------------

// File: rtl/game_layer_mixer.sv
// Priority compositor: NUM_LAYERS keyed sprite windows over a 2x-upscaled 8-bit background.
// Three-stage pipeline (address / ROM / output) with double-buffered window configuration.
module game_layer_mixer #(
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned ADDR_W     = 17,
  parameter logic [11:0] KEY_COLOR  = 12'h000,
  parameter int unsigned BG_W       = 320
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [10:0]                  VGA_xpos,
  input  logic [10:0]                  VGA_ypos,
  input  logic                         frame_start,
  input  logic                         blink_tick,
  input  logic                         cfg_we,
  input  logic [2:0]                   cfg_sel,
  input  logic [10:0]                  cfg_x0,
  input  logic [10:0]                  cfg_y0,
  input  logic [10:0]                  cfg_w,
  input  logic [10:0]                  cfg_h,
  input  logic                         cfg_en,
  input  logic                         cfg_blink,
  output logic                         cfg_pending,
  output logic [ADDR_W-1:0]            bg_addr,
  input  logic [7:0]                   bg_pix,
  output logic [NUM_LAYERS*ADDR_W-1:0] layer_addr,
  input  logic [NUM_LAYERS*12-1:0]     layer_pix,
  output logic [11:0]                  VGA_data
);

  typedef struct packed {
    logic [10:0] x0;
    logic [10:0] y0;
    logic [10:0] w;
    logic [10:0] h;
    logic        en;
    logic        blink;
  } cfg_t;

  cfg_t cfg_in;
  cfg_t shadow_q [NUM_LAYERS];
  cfg_t shadow_d [NUM_LAYERS];
  cfg_t active_q [NUM_LAYERS];
  logic wr_hit;
  logic pending_q;
  logic blink_phase_q;

  assign cfg_in = {cfg_x0, cfg_y0, cfg_w, cfg_h, cfg_en, cfg_blink};

  // Out-of-range selects match no layer, so they neither write nor raise pending.
  always_comb begin
    wr_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      shadow_d[i] = shadow_q[i];
      if (cfg_we && (cfg_sel == 3'(i))) begin
        shadow_d[i] = cfg_in;
        wr_hit      = 1'b1;
      end
    end
  end

  // Commit copies shadow_d so a write in the frame_start cycle is included.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      pending_q     <= 1'b0;
      blink_phase_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
        shadow_q[i] <= shadow_d[i];
        if (frame_start) active_q[i] <= shadow_d[i];
      end
      pending_q     <= frame_start ? 1'b0 : (pending_q | wr_hit);
      blink_phase_q <= blink_phase_q ^ blink_tick;
    end
  end

  assign cfg_pending = pending_q;

  // Stage A: window hit test and ROM address generation.
  logic [NUM_LAYERS-1:0] hit;
  logic [NUM_LAYERS-1:0] vis;
  logic [ADDR_W-1:0]     layer_addr_d [NUM_LAYERS];
  logic                  in_area;
  logic [ADDR_W-1:0]     bg_addr_d;

  always_comb begin
    hit = '0;
    vis = '0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      // Window end computed at 12 bits so windows near 2047 do not wrap.
      hit[i] = active_q[i].en
            && (VGA_xpos > active_q[i].x0)
            && ({1'b0, VGA_xpos} <= {1'b0, active_q[i].x0} + {1'b0, active_q[i].w})
            && (VGA_ypos > active_q[i].y0)
            && ({1'b0, VGA_ypos} <= {1'b0, active_q[i].y0} + {1'b0, active_q[i].h});
      vis[i] = hit[i] && !(active_q[i].blink && blink_phase_q);
      layer_addr_d[i] = ADDR_W'((22'(VGA_xpos) - 22'(active_q[i].x0) - 22'd1)
                        + 22'(active_q[i].w) * (22'(VGA_ypos) - 22'(active_q[i].y0) - 22'd1));
    end
  end

  assign in_area   = (VGA_xpos >= 11'd1) && (VGA_xpos <= 11'd640)
                  && (VGA_ypos >= 11'd1) && (VGA_ypos <= 11'd480);
  assign bg_addr_d = ADDR_W'(32'(VGA_xpos[10:1]) + BG_W * 32'(VGA_ypos[10:1]));

  logic [NUM_LAYERS-1:0] vis_q;
  logic [NUM_LAYERS-1:0] vis_qq;
  logic                  valid_q;
  logic                  valid_qq;
  logic [11:0]           vga_d;
  logic [11:0]           vga_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bg_addr    <= '0;
      layer_addr <= '0;
      vis_q      <= '0;
      vis_qq     <= '0;
      valid_q    <= 1'b0;
      valid_qq   <= 1'b0;
      vga_q      <= '0;
    end else begin
      if (in_area) bg_addr <= bg_addr_d;
      for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
        if (hit[i]) layer_addr[i*ADDR_W +: ADDR_W] <= layer_addr_d[i];
      end
      vis_q    <= vis;
      vis_qq   <= vis_q;
      valid_q  <= 1'b1;
      valid_qq <= valid_q;
      vga_q    <= vga_d;
    end
  end

  // Stage C: ascending scan lets the highest-index opaque layer win.
  always_comb begin
    vga_d = {bg_pix[7:5], bg_pix[7], bg_pix[4:2], bg_pix[4], bg_pix[1:0], bg_pix[1:0]};
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (vis_qq[i] && (layer_pix[i*12 +: 12] != KEY_COLOR)) vga_d = layer_pix[i*12 +: 12];
    end
    if (!valid_qq) vga_d = '0;
  end

  assign VGA_data = vga_q;

endmodule

// File: tb/tb_game_layer_mixer.sv
// Scoreboard bench for game_layer_mixer: random scan positions and config events are
// scored against a frame-level reference model with behavioural ROMs.
module tb_game_layer_mixer;
  localparam int          N    = 4;
  localparam int          AW   = 17;
  localparam logic [11:0] KEY  = 12'h000;
  localparam int          MASK = (1 << AW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [10:0]       VGA_xpos, VGA_ypos;
  logic              frame_start, blink_tick, cfg_we;
  logic [2:0]        cfg_sel;
  logic [10:0]       cfg_x0, cfg_y0, cfg_w, cfg_h;
  logic              cfg_en, cfg_blink;
  logic              cfg_pending;
  logic [AW-1:0]     bg_addr;
  logic [7:0]        bg_pix;
  logic [N*AW-1:0]   layer_addr;
  logic [N*12-1:0]   layer_pix;
  logic [11:0]       VGA_data;

  always #5 clk = ~clk;

  game_layer_mixer #(
    .NUM_LAYERS(N),
    .ADDR_W    (AW),
    .KEY_COLOR (KEY),
    .BG_W      (320)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .VGA_xpos   (VGA_xpos),
    .VGA_ypos   (VGA_ypos),
    .frame_start(frame_start),
    .blink_tick (blink_tick),
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_x0     (cfg_x0),
    .cfg_y0     (cfg_y0),
    .cfg_w      (cfg_w),
    .cfg_h      (cfg_h),
    .cfg_en     (cfg_en),
    .cfg_blink  (cfg_blink),
    .cfg_pending(cfg_pending),
    .bg_addr    (bg_addr),
    .bg_pix     (bg_pix),
    .layer_addr (layer_addr),
    .layer_pix  (layer_pix),
    .VGA_data   (VGA_data)
  );

  // Layer ROM contents: some keyed pixels, layer 1 otherwise solid yellow.
  function automatic logic [11:0] lpix(int i, int a);
    if (((a * 7 + i * 3) % 5) == 0) return KEY;
    if (i == 1) return 12'hFF0;
    return 12'((i + 1) * 256) ^ 12'(a & 255);
  endfunction

  always @(posedge clk) begin
    bg_pix <= bg_addr[7:0];
    for (int i = 0; i < N; i++) layer_pix[i*12 +: 12] <= lpix(i, int'(layer_addr[i*AW +: AW]));
  end

  // Reference model state.
  typedef struct {int x0; int y0; int w; int h; bit en; bit bl;} mcfg_t;
  typedef struct {int due; logic [11:0] val;} pix_exp_t;
  typedef struct {int due; logic val;} pend_exp_t;

  mcfg_t     act [N];
  mcfg_t     shd [N];
  bit        m_pend, m_phase;
  int        m_bg;
  pix_exp_t  pix_q[$];
  pend_exp_t pend_q[$];
  int        cyc = 0;
  int        checks = 0;
  int        failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [11:0] expand(logic [7:0] b);
    return {b[7:5], b[7], b[4:2], b[4], b[1:0], b[1:0]};
  endfunction

  function automatic logic [11:0] ref_pixel(int x, int y);
    logic [11:0] p;
    int a;
    if (x >= 1 && x <= 640 && y >= 1 && y <= 480) m_bg = ((x / 2) + 320 * (y / 2)) & MASK;
    for (int i = N - 1; i >= 0; i--) begin
      if (act[i].en && !(act[i].bl && m_phase) &&
          x > act[i].x0 && x <= act[i].x0 + act[i].w &&
          y > act[i].y0 && y <= act[i].y0 + act[i].h) begin
        a = ((x - act[i].x0 - 1) + act[i].w * (y - act[i].y0 - 1)) & MASK;
        p = lpix(i, a);
        if (p != KEY) return p;
      end
    end
    return expand(8'(m_bg & 255));
  endfunction

  // Scores the current cycle's inputs, advances the model, then moves to the next cycle.
  task automatic cycle();
    pix_exp_t  e;
    pend_exp_t pe;
    int        s;
    e.due = cyc + 3;
    if (rst) begin
      e.val = '0;
      foreach (pix_q[k]) if (pix_q[k].due > cyc) pix_q[k].val = '0;
    end else begin
      e.val = ref_pixel(int'(VGA_xpos), int'(VGA_ypos));
    end
    pix_q.push_back(e);
    s = int'(cfg_sel);
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        act[i] = '{0, 0, 0, 0, 1'b0, 1'b0};
        shd[i] = '{0, 0, 0, 0, 1'b0, 1'b0};
      end
      m_pend  = 1'b0;
      m_phase = 1'b0;
      m_bg    = 0;
    end else begin
      if (cfg_we && s < N)
        shd[s] = '{int'(cfg_x0), int'(cfg_y0), int'(cfg_w), int'(cfg_h), cfg_en, cfg_blink};
      if (frame_start) begin
        act    = shd;
        m_pend = 1'b0;
      end else if (cfg_we && s < N) begin
        m_pend = 1'b1;
      end
      if (blink_tick) m_phase = !m_phase;
    end
    pe.due = cyc + 1;
    pe.val = m_pend;
    pend_q.push_back(pe);
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    blink_tick  = 1'b0;
    cfg_we      = 1'b0;
  endtask

  always @(negedge clk) begin
    pix_exp_t  e;
    pend_exp_t pe;
    while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
      e = pix_q.pop_front();
      check("VGA_data", 32'(VGA_data), 32'(e.val));
    end
    while (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      pe = pend_q.pop_front();
      check("cfg_pending", 32'(cfg_pending), 32'(pe.val));
    end
  end

  task automatic pos(input int x, input int y);
    VGA_xpos = 11'(x);
    VGA_ypos = 11'(y);
    cycle();
  endtask

  task automatic rand_pos();
    if ($urandom_range(0, 9) == 0) pos($urandom_range(0, 2047), $urandom_range(0, 2047));
    else pos($urandom_range(0, 700), $urandom_range(0, 520));
  endtask

  task automatic wr(input int sel, input int x0, input int y0, input int w, input int h,
                    input bit en, input bit bl);
    cfg_we    = 1'b1;
    cfg_sel   = 3'(sel);
    cfg_x0    = 11'(x0);
    cfg_y0    = 11'(y0);
    cfg_w     = 11'(w);
    cfg_h     = 11'(h);
    cfg_en    = en;
    cfg_blink = bl;
  endtask

  task automatic rand_wr();
    int x0, y0;
    x0 = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1900, 2047)) : int'($urandom_range(0, 600));
    y0 = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1900, 2047)) : int'($urandom_range(0, 450));
    wr($urandom_range(0, 7), x0, y0,
       ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 400)),
       ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 300)),
       $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0);
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    frame_start = 1'b0; blink_tick = 1'b0; cfg_we = 1'b0; cfg_sel = '0;
    cfg_x0 = '0; cfg_y0 = '0; cfg_w = '0; cfg_h = '0; cfg_en = 1'b0; cfg_blink = 1'b0;
    VGA_xpos = '0; VGA_ypos = '0;
    repeat (3) pos(10, 10);
    rst = 1'b0;
    check("rst_bg_addr", 32'(bg_addr), 32'd0);
    check("rst_layer_addr", 32'(layer_addr[3*AW +: AW] | layer_addr[0 +: AW]), 32'd0);

    // Background only.
    repeat (300) rand_pos();
    pos(3, 5);
    check("bg_addr_3_5", 32'(bg_addr), 32'd641);
    pos(0, 0);
    check("bg_addr_hold", 32'(bg_addr), 32'd641);
    for (int y = 1; y <= 2; y++) for (int x = 1; x <= 640; x++) pos(x, y);

    // Layer 0 window and commit handshake.
    wr(0, 130, 120, 380, 180, 1'b1, 1'b0);
    pos(1, 1);
    check("pend_after_wr", 32'(cfg_pending), 32'd1);
    frame_start = 1'b1;
    pos(1, 1);
    check("pend_after_commit", 32'(cfg_pending), 32'd0);
    pos(131, 121);
    check("l0_addr_first", 32'(layer_addr[0 +: AW]), 32'd0);
    pos(510, 300);
    check("l0_addr_last", 32'(layer_addr[0 +: AW]), 32'd68399);
    pos(511, 300);
    check("l0_addr_hold", 32'(layer_addr[0 +: AW]), 32'd68399);
    repeat (1500) rand_pos();

    // Overlapping layer 1, written in the same cycle as the commit.
    wr(1, 300, 200, 300, 200, 1'b1, 1'b0);
    frame_start = 1'b1;
    pos(5, 5);
    check("pend_we_with_fs", 32'(cfg_pending), 32'd0);
    repeat (1500) pos($urandom_range(100, 700), $urandom_range(100, 520));

    // Uncommitted write must not change the picture; out-of-range select is ignored.
    wr(0, 0, 0, 640, 480, 1'b1, 1'b0);
    pos(200, 200);
    check("pend_midframe", 32'(cfg_pending), 32'd1);
    repeat (500) rand_pos();
    frame_start = 1'b1;
    pos(1, 1);
    repeat (300) rand_pos();
    wr(5, 0, 0, 700, 500, 1'b1, 1'b0);
    pos(50, 50);
    check("pend_sel5_ignored", 32'(cfg_pending), 32'd0);
    repeat (300) rand_pos();

    // Blinking layer 2 over everything.
    wr(2, 0, 0, 700, 500, 1'b1, 1'b1);
    frame_start = 1'b1;
    pos(1, 1);
    for (int k = 0; k < 6; k++) begin
      blink_tick = 1'b1;
      repeat (150) rand_pos();
    end

    // Mid-frame reset.
    pos(320, 240);
    rst = 1'b1;
    pos(321, 240);
    rst = 1'b0;
    repeat (400) rand_pos();

    // Random mix of positions, config traffic, commits, blinks and resets.
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 199) == 0) frame_start = 1'b1;
      if ($urandom_range(0, 49) == 0) blink_tick = 1'b1;
      if ($urandom_range(0, 39) == 0) rand_wr();
      rst = ($urandom_range(0, 1499) == 0);
      rand_pos();
    end
    rst = 1'b0;
    repeat (10) rand_pos();

    guard = 0;
    while ((pix_q.size() > 0 || pend_q.size() > 0) && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    checks++;
    if (pix_q.size() > 0 || pend_q.size() > 0) begin
      failures++;
      $display("FAIL drain got=%0d expected=0 (entries left)", pix_q.size() + pend_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
